// File: rtl/slave_i2c_pkg.sv
// Shared definitions for the I2C slave transmit path: sequencer states,
// byte geometry and the bus levels used for the master ACK/NACK bit.
package slave_i2c_pkg;

   localparam int BYTE_BITS = 8;
   localparam int BIT_CNT_W = 3;

   // SDA level the master drives in the ninth bit
   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;

   // Index of the first bit on the wire (MSB first)
   localparam logic [BIT_CNT_W-1:0] LAST_BIT_IDX = BIT_CNT_W'(BYTE_BITS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      DRIVE    = 3'd2,
      ACK      = 3'd3,
      ACK_WAIT = 3'd4
   } tx_state_e;

   // True when the sampled ninth bit means the master wants no more data
   function automatic logic is_nack(input logic sda_level);
      return (sda_level == NACK_LVL);
   endfunction

endpackage

// File: rtl/slave_stretch_timer.sv
// Counts oversampling cycles while SCL is held low waiting for transmit data.
// Terminal count flags that the stretch has lasted STRETCH_MAX cycles.
module slave_stretch_timer
   import slave_i2c_pkg::*;
#(
   parameter int STRETCH_MAX = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (STRETCH_MAX < 2) ? 1 : $clog2(STRETCH_MAX + 1);

   logic [CW-1:0] cnt_r;
   logic          tc_s;

   assign tc_s = (cnt_r == CW'(STRETCH_MAX));
   assign tc   = tc_s;

   // Stretch cycle counter: clear has priority, saturates at terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= CW'(0);
      end else if (clr) begin
         cnt_r <= CW'(0);
      end else if (en && !tc_s) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/slave_tx_ctrl.sv
// Transmit sequencer for the I2C slave read path. Pops bytes from the
// transmit byte source into the data PISO, shifts them out on SCL falling
// edges, releases SDA for the master ACK bit and stretches SCL while no
// byte is available. Every output is a register.
module slave_tx_ctrl
   import slave_i2c_pkg::*;
#(
   parameter int STRETCH_MAX = 255,
   parameter int CNT_W       = 8
) (
   input  logic             slave_scl_sixt,
   input  logic             slave_rst_n,
   input  logic             slave_tx_start,
   input  logic             slave_scl_fall,
   input  logic             slave_scl_rise,
   input  logic             slave_sda_in,
   input  logic             slave_start_det,
   input  logic             slave_stop_det,
   input  logic             slave_tx_valid,
   output logic             slave_tx_rd,
   output logic             slave_load_data,
   output logic             slave_shift_data,
   output logic             slave_sda_oe,
   output logic             slave_scl_stretch,
   output logic             slave_tx_busy,
   output logic [CNT_W-1:0] slave_byte_cnt,
   output logic             slave_nack_det,
   output logic             slave_underrun
);

   tx_state_e              state_r, state_nx_s;
   logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_nx_s;
   logic [CNT_W-1:0]       byte_cnt_r, byte_cnt_nx_s;
   logic                   nack_r, nack_nx_s;
   logic                   underrun_r, underrun_nx_s;
   logic                   load_r, load_nx_s;
   logic                   shift_r, shift_nx_s;
   logic                   rd_r, rd_nx_s;
   logic                   sda_oe_r, sda_oe_nx_s;
   logic                   stretch_r, stretch_nx_s;
   logic                   busy_r, busy_nx_s;

   logic                   tmr_clr_s, tmr_en_s, tmr_tc_s;
   logic                   fall_only_s, rise_only_s;
   logic                   bus_abort_s;

   // Coincident rise and fall is treated as a glitch and ignored
   assign fall_only_s = slave_scl_fall & ~slave_scl_rise;
   assign rise_only_s = slave_scl_rise & ~slave_scl_fall;
   assign bus_abort_s = slave_start_det | slave_stop_det;

   slave_stretch_timer #(
      .STRETCH_MAX (STRETCH_MAX)
   ) u_stretch_timer (
      .clk   (slave_scl_sixt),
      .rst_n (slave_rst_n),
      .clr   (tmr_clr_s),
      .en    (tmr_en_s),
      .tc    (tmr_tc_s)
   );

   // Next-state and next-output decode; bus START/STOP overrides everything
   always_comb begin
      state_nx_s    = state_r;
      bit_cnt_nx_s  = bit_cnt_r;
      byte_cnt_nx_s = byte_cnt_r;
      nack_nx_s     = nack_r;
      underrun_nx_s = underrun_r;
      load_nx_s     = 1'b0;
      shift_nx_s    = 1'b0;
      rd_nx_s       = 1'b0;
      sda_oe_nx_s   = 1'b0;
      stretch_nx_s  = 1'b0;
      tmr_clr_s     = 1'b1;
      tmr_en_s      = 1'b0;

      if (bus_abort_s) begin
         state_nx_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (slave_tx_start) begin
                  state_nx_s    = LOAD;
                  byte_cnt_nx_s = CNT_W'(0);
                  nack_nx_s     = 1'b0;
                  underrun_nx_s = 1'b0;
               end else begin
                  state_nx_s = IDLE;
               end
            end

            LOAD: begin
               tmr_clr_s = 1'b0;
               if (slave_tx_valid) begin
                  // stretch drops in the same cycle the load is pulsed
                  load_nx_s    = 1'b1;
                  rd_nx_s      = 1'b1;
                  sda_oe_nx_s  = 1'b1;
                  bit_cnt_nx_s = LAST_BIT_IDX;
                  state_nx_s   = DRIVE;
               end else if (tmr_tc_s) begin
                  underrun_nx_s = 1'b1;
                  state_nx_s    = IDLE;
               end else begin
                  stretch_nx_s = 1'b1;
                  tmr_en_s     = 1'b1;
               end
            end

            DRIVE: begin
               sda_oe_nx_s = 1'b1;
               if (fall_only_s) begin
                  if (bit_cnt_r != BIT_CNT_W'(0)) begin
                     shift_nx_s   = 1'b1;
                     bit_cnt_nx_s = bit_cnt_r - BIT_CNT_W'(1);
                  end else begin
                     // all 8 bits out: let the master own SDA for the ACK
                     sda_oe_nx_s = 1'b0;
                     state_nx_s  = ACK;
                  end
               end else begin
                  state_nx_s = DRIVE;
               end
            end

            ACK: begin
               if (rise_only_s) begin
                  byte_cnt_nx_s = byte_cnt_r + CNT_W'(1);
                  if (is_nack(slave_sda_in)) begin
                     nack_nx_s  = 1'b1;
                     state_nx_s = IDLE;
                  end else begin
                     state_nx_s = ACK_WAIT;
                  end
               end else begin
                  state_nx_s = ACK;
               end
            end

            ACK_WAIT: begin
               if (fall_only_s) begin
                  state_nx_s = LOAD;
               end else begin
                  state_nx_s = ACK_WAIT;
               end
            end

            default: begin
               state_nx_s = IDLE;
            end
         endcase
      end

      busy_nx_s = (state_nx_s != IDLE);
   end

   // State and output registers; async reset releases SDA and SCL at once
   always_ff @(posedge slave_scl_sixt or negedge slave_rst_n) begin
      if (!slave_rst_n) begin
         state_r    <= IDLE;
         bit_cnt_r  <= BIT_CNT_W'(0);
         byte_cnt_r <= CNT_W'(0);
         nack_r     <= 1'b0;
         underrun_r <= 1'b0;
         load_r     <= 1'b0;
         shift_r    <= 1'b0;
         rd_r       <= 1'b0;
         sda_oe_r   <= 1'b0;
         stretch_r  <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         bit_cnt_r  <= bit_cnt_nx_s;
         byte_cnt_r <= byte_cnt_nx_s;
         nack_r     <= nack_nx_s;
         underrun_r <= underrun_nx_s;
         load_r     <= load_nx_s;
         shift_r    <= shift_nx_s;
         rd_r       <= rd_nx_s;
         sda_oe_r   <= sda_oe_nx_s;
         stretch_r  <= stretch_nx_s;
         busy_r     <= busy_nx_s;
      end
   end

   assign slave_tx_rd       = rd_r;
   assign slave_load_data   = load_r;
   assign slave_shift_data  = shift_r;
   assign slave_sda_oe      = sda_oe_r;
   assign slave_scl_stretch = stretch_r;
   assign slave_tx_busy     = busy_r;
   assign slave_byte_cnt    = byte_cnt_r;
   assign slave_nack_det    = nack_r;
   assign slave_underrun    = underrun_r;

endmodule
